writeback_unit: RTL

Registered, handshaked writeback stage for the RISC-V core; the parametrised successor of the combinational result-select mux. It selects the register-file write value among ALU result, load data, PC+4 and immediate. It sizes and extends sub-word loads (LB/LH/LW/LBU/LHU) and waits a variable number of cycles for data memory. It presents one registered write per instruction to the register file, with a stall output and a timeout error.

---
 rtl/writeback_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// Registered writeback stage: picks the register-file write value, sizes and extends
// sub-word loads, waits on data memory with a timeout, and emits one write pulse per instruction.
module writeback_unit #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ResultSrc,
    input  logic [2:0]      funct3,
    input  logic            RegWrite,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] ALUResult,
    input  logic [XLEN-1:0] PCPlus4,
    input  logic [XLEN-1:0] ImmExt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] MemoryData,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_err,
    output logic            stall
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT = CW'(MEM_TIMEOUT);

    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0] cap_f3;
    logic [1:0] cap_off;
    logic       cap_rw;
    logic [4:0] cap_rd;

    logic            accept;
    logic [2:0]      ld_f3;
    logic [1:0]      ld_off;
    logic            ld_rw;
    logic [4:0]      ld_rd;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_val;
    logic            ld_bad;
    logic [XLEN-1:0] sel_val;

    logic            done, err_nxt, we_nxt, cnt_clr, cnt_inc;
    logic [XLEN-1:0] data_nxt;

    assign in_ready = (state == IDLE);
    assign stall    = (state == WAIT_MEM);
    assign accept   = in_valid && in_ready;

    // Zero-wait loads extract from the live request; waiting loads use the captured one.
    always_comb begin
        ld_f3  = cap_f3;
        ld_off = cap_off;
        ld_rw  = cap_rw;
        ld_rd  = cap_rd;
        if (state == IDLE) begin
            ld_f3  = funct3;
            ld_off = ALUResult[1:0];
            ld_rw  = RegWrite;
            ld_rd  = rd;
        end
    end

    always_comb begin
        ld_byte = MemoryData[8*ld_off +: 8];
        ld_half = MemoryData[16*ld_off[1] +: 16];
        ld_val  = '0;
        ld_bad  = 1'b0;
        case (ld_f3)
            3'b000: ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100: ld_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001: begin
                ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
                ld_bad = ld_off[0];
            end
            3'b101: begin
                ld_val = {{(XLEN-16){1'b0}}, ld_half};
                ld_bad = ld_off[0];
            end
            3'b010: begin
                ld_val = MemoryData;
                ld_bad = (ld_off != 2'b00);
            end
            default: ld_bad = 1'b1;
        endcase
    end

    always_comb begin
        case (ResultSrc)
            2'b00:   sel_val = ALUResult;
            2'b01:   sel_val = MemoryData;
            2'b10:   sel_val = PCPlus4;
            default: sel_val = ImmExt;
        endcase
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        err_nxt   = 1'b0;
        we_nxt    = 1'b0;
        data_nxt  = '0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (ResultSrc != 2'b01) begin
                        done     = 1'b1;
                        data_nxt = sel_val;
                        we_nxt   = RegWrite && (rd != 5'd0);
                    end else if (mem_rvalid) begin
                        done     = 1'b1;
                        err_nxt  = ld_bad;
                        data_nxt = ld_bad ? '0 : ld_val;
                        we_nxt   = !ld_bad && ld_rw && (ld_rd != 5'd0);
                    end else begin
                        state_nxt = WAIT_MEM;
                        cnt_clr   = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                // Data arriving on the timeout cycle still completes normally.
                if (mem_rvalid) begin
                    done      = 1'b1;
                    err_nxt   = ld_bad;
                    data_nxt  = ld_bad ? '0 : ld_val;
                    we_nxt    = !ld_bad && ld_rw && (ld_rd != 5'd0);
                    state_nxt = IDLE;
                end else if (cnt == TIMEOUT) begin
                    done      = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_f3   <= '0;
            cap_off  <= '0;
            cap_rw   <= 1'b0;
            cap_rd   <= '0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_err   <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            state    <= state_nxt;
            wb_valid <= done;
            wb_we    <= we_nxt;
            wb_err   <= err_nxt;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            if (accept) begin
                cap_f3  <= funct3;
                cap_off <= ALUResult[1:0];
                cap_rw  <= RegWrite;
                cap_rd  <= rd;
            end
            if (done) begin
                wb_rd   <= ld_rd;
                wb_data <= data_nxt;
            end
        end
    end
endmodule
